rob_param: RTL and testbench
============================

ROB_PARAM -- requirements
Module: rob_param

Interface
REQ-001 SHALL have parameter DEPTH, default 16: entry count, power of two, 4..64.
REQ-002 SHALL have parameter TAGW, default 4: tag width, equal to log2(DEPTH).
REQ-003 SHALL have parameter DW, default 32: result data width.
REQ-004 SHALL have parameter NWB, default 2: writeback port count, 1..4.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have ports alloc_req, alloc_S, alloc_ST, alloc_V, all input, 1 each: allocation request and entry flags.
REQ-008 SHALL have port alloc_rd, input, 5: allocation destination register.
REQ-009 SHALL have ports alloc_gnt, output, 1, and alloc_tag, output, TAGW: grant and allocated tag.
REQ-010 SHALL have ports wb_valid, input, NWB; wb_tag, input, NWB*TAGW; wb_data, input, NWB*DW; wb_exc, input, NWB: per-port writeback, port i in slice i.
REQ-011 SHALL have ports commit_allow, input, 1 (commit enable) and flush, input, 1 (external squash).
REQ-012 SHALL have port commit_fire, output, 2: per-lane commit strobe, lane 0 = head, lane 1 = head+1.
REQ-013 SHALL have ports commit_tag, output, 2*TAGW; commit_S, commit_ST, commit_V, output, 2 each; commit_rd, output, 10; commit_value, output, 2*DW: per-lane commit payload.
REQ-014 SHALL have port commit_exc, output, 1: lane-0 commit of an excepting entry.
REQ-015 SHALL have ports head_ptr and tail_ptr, output, TAGW; count_out, output, TAGW+1; empty and full, output, 1 each.
REQ-016 SHALL have port dump_state, output, 2*DEPTH: per-entry state, entry DEPTH-1 in the MSBs.

Function
REQ-017 Entry states SHALL be FREE=00, PEND=01 and FIN=10; each entry SHALL also hold S, ST, V, rd, value and an exc bit.
REQ-018 Definitions: empty = (count==0); full = (count==DEPTH); both come from registered count.
REQ-019 Definition: xcommit = commit_fire[0] & head exc bit.
REQ-020 alloc_gnt SHALL equal alloc_req & ~full & ~flush & ~xcommit, combinationally.
REQ-021 alloc_tag SHALL equal tail.
REQ-022 On a grant, the tail entry SHALL become PEND with its flags and rd loaded, and its value and exc bit cleared.
REQ-023 A writeback on port i SHALL set entry wb_tag[i] to FIN and load value and exc, but only when that entry is PEND.
REQ-024 A writeback to a FREE or FIN entry SHALL be ignored.
REQ-025 When several writeback ports hit the same tag in one cycle, the highest-numbered port SHALL win.
REQ-026 commit_fire[0] SHALL equal head FIN & ~empty & commit_allow & ~flush.
REQ-027 commit_fire[1] SHALL equal commit_fire[0] & (count>=2) & entry head+1 FIN & ~head exc & ~(entry head+1 exc) & ~(head ST & entry head+1 ST).
REQ-028 Commit rule: at most one store commits per cycle; an excepting entry commits only in lane 0.
REQ-029 Commit payload SHALL be combinational from entries head and head+1 (mod DEPTH), valid whenever the matching commit_fire bit is 1.
REQ-030 A committed entry SHALL be cleared to FREE with all fields zero at the clock edge; this clear overrides a same-cycle writeback to that tag.
REQ-031 Pointer update: head += number of commits; tail += alloc_gnt; both wrap modulo DEPTH.
REQ-032 Count update: count += alloc_gnt - commits, giving net 0 for one alloc with one commit and net -1 for one alloc with two commits.
REQ-033 An external flush SHALL, at the next edge, set every entry FREE with fields zeroed and set head=tail=count=0.
REQ-034 During a flush cycle, writebacks SHALL be ignored and no commit SHALL fire.
REQ-035 xcommit SHALL assert commit_exc for that cycle and trigger the same clear as REQ-033 at the same edge.
REQ-036 Latency: an allocation is visible in state the next cycle; an entry written back in cycle N can commit in cycle N+1.
REQ-037 While full with a commit in the same cycle, the allocation SHALL stay blocked, because full is registered.

Reset
REQ-038 Under rst=1 at a clock edge, all entries SHALL be FREE and zeroed, and head=tail=count=0.
REQ-039 The resulting output values SHALL be empty=1, full=0, alloc_gnt=0, commit_fire=00, commit_exc=0 and dump_state=0.
REQ-040 rst SHALL override flush, allocation, writeback and commit in the same cycle; reset mid-operation discards all entries.

Verification
REQ-041 Reset, then 16 allocations -> tags 0..15, count=16, full=1, 17th request gnt=0; wb tags 0,1 -> next cycle commit_fire=11, then commits continue two per cycle.
REQ-042 Fill 16; wb0 and wb1 both to tag 3 with data 0xA and 0xB -> value[3]=0xB; wb to FREE tag 5 after its commit -> no state change.
REQ-043 Head=14, tail wraps: alloc 4 -> tags 14,15,0,1; commits wrap head 15->0 -> head_ptr=2 after all commits.
REQ-044 Entries 0,1 FIN, 0 excepting -> commit_fire=01, commit_exc=1, alloc_gnt=0 that cycle; next cycle empty=1, dump_state=0.
REQ-045 Entries 0,1 FIN, both ST -> commit_fire=01 then 01; flush with 5 pending -> next cycle count=0, head=tail=0.

Source files
------------

// File: rtl/rob_param.sv
// rtl/rob_param.sv - parameterised reorder buffer: in-order allocation, multi-port writeback, dual-lane commit.
module rob_param #(
  parameter int DEPTH = 16,
  parameter int TAGW  = 4,
  parameter int DW    = 32,
  parameter int NWB   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_req,
  input  logic                alloc_S,
  input  logic                alloc_ST,
  input  logic                alloc_V,
  input  logic [4:0]          alloc_rd,
  output logic                alloc_gnt,
  output logic [TAGW-1:0]     alloc_tag,
  input  logic [NWB-1:0]      wb_valid,
  input  logic [NWB*TAGW-1:0] wb_tag,
  input  logic [NWB*DW-1:0]   wb_data,
  input  logic [NWB-1:0]      wb_exc,
  input  logic                commit_allow,
  input  logic                flush,
  output logic [1:0]          commit_fire,
  output logic [2*TAGW-1:0]   commit_tag,
  output logic [1:0]          commit_S,
  output logic [1:0]          commit_ST,
  output logic [1:0]          commit_V,
  output logic [9:0]          commit_rd,
  output logic [2*DW-1:0]     commit_value,
  output logic                commit_exc,
  output logic [TAGW-1:0]     head_ptr,
  output logic [TAGW-1:0]     tail_ptr,
  output logic [TAGW:0]       count_out,
  output logic                empty,
  output logic                full,
  output logic [2*DEPTH-1:0]  dump_state
);

  typedef enum logic [1:0] {FREE = 2'b00, PEND = 2'b01, FIN = 2'b10} ent_state_t;

  ent_state_t      ent_q [DEPTH];
  logic            s_q   [DEPTH];
  logic            st_q  [DEPTH];
  logic            v_q   [DEPTH];
  logic            exc_q [DEPTH];
  logic [4:0]      rd_q  [DEPTH];
  logic [DW-1:0]   val_q [DEPTH];

  logic [TAGW-1:0] head, tail, head1;
  logic [TAGW:0]   count;
  logic            fire0, fire1, xcommit, wipe;

  assign head1 = head + TAGW'(1);
  assign empty = (count == '0);
  assign full  = (count == (TAGW+1)'(DEPTH));

  assign fire0 = (ent_q[head] == FIN) & ~empty & commit_allow & ~flush;
  // Lane 1 never carries an exception and never pairs two stores.
  assign fire1 = fire0 & (count >= (TAGW+1)'(2)) & (ent_q[head1] == FIN)
               & ~exc_q[head] & ~exc_q[head1] & ~(st_q[head] & st_q[head1]);
  assign xcommit = fire0 & exc_q[head];
  assign wipe    = rst | flush | xcommit;

  assign alloc_gnt = alloc_req & ~full & ~flush & ~xcommit;
  assign alloc_tag = tail;

  assign commit_fire  = {fire1, fire0};
  assign commit_exc   = xcommit;
  assign commit_tag   = {head1, head};
  assign commit_S     = {s_q[head1], s_q[head]};
  assign commit_ST    = {st_q[head1], st_q[head]};
  assign commit_V     = {v_q[head1], v_q[head]};
  assign commit_rd    = {rd_q[head1], rd_q[head]};
  assign commit_value = {val_q[head1], val_q[head]};

  assign head_ptr  = head;
  assign tail_ptr  = tail;
  assign count_out = count;

  for (genvar g = 0; g < DEPTH; g++) begin : g_dump
    assign dump_state[2*g +: 2] = ent_q[g];
  end

  always_ff @(posedge clk) begin
    if (alloc_gnt) begin
      ent_q[tail] <= PEND;
      s_q[tail]   <= alloc_S;
      st_q[tail]  <= alloc_ST;
      v_q[tail]   <= alloc_V;
      rd_q[tail]  <= alloc_rd;
      val_q[tail] <= '0;
      exc_q[tail] <= 1'b0;
    end
    // Ascending port order lets the highest-numbered port win a tag collision.
    for (int p = 0; p < NWB; p++) begin
      if (wb_valid[p] && ent_q[wb_tag[p*TAGW +: TAGW]] == PEND) begin
        ent_q[wb_tag[p*TAGW +: TAGW]] <= FIN;
        val_q[wb_tag[p*TAGW +: TAGW]] <= wb_data[p*DW +: DW];
        exc_q[wb_tag[p*TAGW +: TAGW]] <= wb_exc[p];
      end
    end
    // Retirement and squash clears come last so they override writebacks.
    for (int i = 0; i < DEPTH; i++) begin
      if (wipe || (fire0 && head == TAGW'(i)) || (fire1 && head1 == TAGW'(i))) begin
        ent_q[i] <= FREE;
        s_q[i]   <= 1'b0;
        st_q[i]  <= 1'b0;
        v_q[i]   <= 1'b0;
        rd_q[i]  <= '0;
        val_q[i] <= '0;
        exc_q[i] <= 1'b0;
      end
    end
    if (wipe) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + TAGW'(fire0) + TAGW'(fire1);
      tail  <= tail + TAGW'(alloc_gnt);
      count <= count + (TAGW+1)'(alloc_gnt) - (TAGW+1)'(fire0) - (TAGW+1)'(fire1);
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// tb/tb_rob_param.sv - scoreboard bench for rob_param: directed alloc/writeback/commit/flush vectors.
module tb_rob_param;

  logic        clk = 1'b0;
  logic        rst, alloc_req, alloc_S, alloc_ST, alloc_V;
  logic [4:0]  alloc_rd;
  logic        alloc_gnt;
  logic [3:0]  alloc_tag;
  logic [1:0]  wb_valid, wb_exc;
  logic [7:0]  wb_tag;
  logic [63:0] wb_data;
  logic        commit_allow, flush;
  logic [1:0]  commit_fire, commit_S, commit_ST, commit_V;
  logic [7:0]  commit_tag;
  logic [9:0]  commit_rd;
  logic [63:0] commit_value;
  logic        commit_exc;
  logic [3:0]  head_ptr, tail_ptr;
  logic [4:0]  count_out;
  logic        empty, full;
  logic [31:0] dump_state;

  rob_param #(.DEPTH(16), .TAGW(4), .DW(32), .NWB(2)) dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_S(alloc_S), .alloc_ST(alloc_ST),
    .alloc_V(alloc_V), .alloc_rd(alloc_rd), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_exc(wb_exc),
    .commit_allow(commit_allow), .flush(flush), .commit_fire(commit_fire),
    .commit_tag(commit_tag), .commit_S(commit_S), .commit_ST(commit_ST), .commit_V(commit_V),
    .commit_rd(commit_rd), .commit_value(commit_value), .commit_exc(commit_exc),
    .head_ptr(head_ptr), .tail_ptr(tail_ptr), .count_out(count_out), .empty(empty),
    .full(full), .dump_state(dump_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  rd;
    logic        st;
    logic [31:0] val;
    logic        exc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   tb_tail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every fired lane must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int l = 0; l < 2; l++) begin
        if (commit_fire[l]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit: lane %0d tag %0h with no expectation", l, commit_tag[l*4 +: 4]);
          end else begin
            e = sb.pop_front();
            check($sformatf("commit_lane%0d", l),
                  {21'd0, commit_tag[l*4 +: 4], commit_rd[l*5 +: 5], commit_ST[l],
                   commit_value[l*32 +: 32], (l == 0) ? commit_exc : 1'b0},
                  {21'd0, e.tag, e.rd, e.st, e.val, (l == 0) ? e.exc : 1'b0});
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic v0, input logic [3:0] t0, input logic [31:0] d0, input logic e0,
                        input logic v1, input logic [3:0] t1, input logic [31:0] d1, input logic e1);
    wb_valid = {v1, v0};
    wb_tag   = {t1, t0};
    wb_data  = {d1, d0};
    wb_exc   = {e1, e0};
  endtask

  task automatic clr_wb();
    set_wb(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc(input logic [4:0] rd, input logic st, input logic [31:0] val,
                       input logic exc, input bit push);
    alloc_req = 1'b1;
    alloc_rd  = rd;
    alloc_ST  = st;
    #2;
    check("alloc_gnt", {63'd0, alloc_gnt}, 64'd1);
    check("alloc_tag", {60'd0, alloc_tag}, {60'd0, tb_tail[3:0]});
    if (push) sb.push_back('{tag: tb_tail[3:0], rd: rd, st: st, val: val, exc: exc});
    tick();
    alloc_req = 1'b0;
    tb_tail = (tb_tail + 1) % 16;
  endtask

  task automatic do_reset();
    rst = 1'b1; alloc_req = 0; alloc_S = 0; alloc_ST = 0; alloc_V = 1; alloc_rd = 0;
    flush = 0; commit_allow = 1;
    clr_wb();
    tick();
    tick();
    rst = 1'b0;
    tb_tail = 0;
    sb.delete();
    #2;
  endtask

  task automatic wait_empty();
    for (int c = 0; c < 40 && !empty; c++) tick();
    #2;
    check("drain_empty", {63'd0, empty}, 64'd1);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    // Reset state and fill to full.
    do_reset();
    check("rst_empty", {63'd0, empty}, 64'd1);
    check("rst_full", {63'd0, full}, 64'd0);
    check("rst_gnt", {63'd0, alloc_gnt}, 64'd0);
    check("rst_fire", {62'd0, commit_fire}, 64'd0);
    check("rst_exc", {63'd0, commit_exc}, 64'd0);
    check("rst_dump", {32'd0, dump_state}, 64'd0);
    for (int i = 0; i < 16; i++) alloc(5'(i), 1'b0, 32'h100 + i, 1'b0, 1);
    alloc_req = 1'b1;
    #2;
    check("full_count", {59'd0, count_out}, 64'd16);
    check("full_flag", {63'd0, full}, 64'd1);
    check("gnt_when_full", {63'd0, alloc_gnt}, 64'd0);
    tick();
    alloc_req = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) set_wb(1, 4'(2*k), 32'h100 + 2*k, 0, 1, 4'(2*k+1), 32'h100 + 2*k + 1, 0);
      else clr_wb();
      if (k == 1) alloc_req = 1'b1;
      #2;
      check($sformatf("dual_fire_k%0d", k), {62'd0, commit_fire}, (k == 0) ? 64'd0 : 64'd3);
      if (k == 1) check("gnt_full_with_commit", {63'd0, alloc_gnt}, 64'd0);
      tick();
      alloc_req = 1'b0;
    end
    clr_wb();
    #2;
    check("s1_empty", {63'd0, empty}, 64'd1);
    check("s1_head", {60'd0, head_ptr}, 64'd0);
    check("s1_count", {59'd0, count_out}, 64'd0);

    // Writeback collision, FIN-ignore, FREE-ignore.
    do_reset();
    commit_allow = 1'b0;
    for (int i = 0; i < 16; i++) alloc(5'(i), 1'b0, (i == 3) ? 32'hB : 32'h200 + i, 1'b0, 1);
    set_wb(1, 4'd3, 32'hA, 0, 1, 4'd3, 32'hB, 0);
    tick();
    for (int k = 0; k < 8; k++) begin
      set_wb(1, 4'(2*k), (2*k == 3) ? 32'hC : 32'h200 + 2*k, 0,
             1, 4'(2*k+1), (2*k+1 == 3) ? 32'hC : 32'h200 + 2*k + 1, 0);
      tick();
    end
    clr_wb();
    #2;
    check("all_fin_dump", {32'd0, dump_state}, 64'hAAAAAAAA);
    check("no_fire_disallowed", {62'd0, commit_fire}, 64'd0);
    commit_allow = 1'b1;
    wait_empty();
    tick();
    set_wb(1, 4'd5, 32'hDEAD, 1, 0, 0, 0, 0);
    tick();
    clr_wb();
    #2;
    check("wb_free_dump", {32'd0, dump_state}, 64'd0);
    check("wb_free_count", {59'd0, count_out}, 64'd0);

    // Pointer wrap.
    do_reset();
    for (int i = 0; i < 14; i++) alloc(5'(i), 1'b0, 32'h300 + i, 1'b0, 1);
    for (int k = 0; k < 7; k++) begin
      set_wb(1, 4'(2*k), 32'h300 + 2*k, 0, 1, 4'(2*k+1), 32'h300 + 2*k + 1, 0);
      tick();
    end
    clr_wb();
    wait_empty();
    check("pre_wrap_head", {60'd0, head_ptr}, 64'd14);
    check("pre_wrap_tail", {60'd0, tail_ptr}, 64'd14);
    tick();
    alloc(5'd20, 1'b0, 32'h3E, 1'b0, 1);
    alloc(5'd21, 1'b0, 32'h3F, 1'b0, 1);
    alloc(5'd22, 1'b0, 32'h30, 1'b0, 1);
    alloc(5'd23, 1'b0, 32'h31, 1'b0, 1);
    set_wb(1, 4'd14, 32'h3E, 0, 1, 4'd15, 32'h3F, 0);
    tick();
    set_wb(1, 4'd0, 32'h30, 0, 1, 4'd1, 32'h31, 0);
    tick();
    clr_wb();
    wait_empty();
    check("wrap_head", {60'd0, head_ptr}, 64'd2);
    check("wrap_tail", {60'd0, tail_ptr}, 64'd2);

    // Exception commit squashes the rest.
    do_reset();
    commit_allow = 1'b0;
    alloc(5'd5, 1'b0, 32'h4A, 1'b1, 1);
    alloc(5'd6, 1'b0, 32'h4B, 1'b0, 0);
    alloc(5'd7, 1'b0, 32'h4C, 1'b0, 0);
    set_wb(1, 4'd0, 32'h4A, 1, 1, 4'd1, 32'h4B, 0);
    tick();
    clr_wb();
    commit_allow = 1'b1;
    alloc_req = 1'b1;
    #2;
    check("exc_fire", {62'd0, commit_fire}, 64'd1);
    check("exc_flag", {63'd0, commit_exc}, 64'd1);
    check("exc_gnt", {63'd0, alloc_gnt}, 64'd0);
    tick();
    alloc_req = 1'b0;
    tb_tail = 0;
    #2;
    check("exc_empty", {63'd0, empty}, 64'd1);
    check("exc_dump", {32'd0, dump_state}, 64'd0);

    // Store pairing, then flush with pending entries.
    do_reset();
    commit_allow = 1'b0;
    alloc(5'd1, 1'b1, 32'h51, 1'b0, 1);
    alloc(5'd2, 1'b1, 32'h52, 1'b0, 1);
    set_wb(1, 4'd0, 32'h51, 0, 1, 4'd1, 32'h52, 0);
    tick();
    clr_wb();
    commit_allow = 1'b1;
    #2;
    check("st_fire_a", {62'd0, commit_fire}, 64'd1);
    tick();
    #1;
    check("st_fire_b", {62'd0, commit_fire}, 64'd1);
    tick();
    commit_allow = 1'b0;
    for (int i = 0; i < 5; i++) alloc(5'(i), 1'b0, 0, 1'b0, 0);
    set_wb(1, 4'd2, 32'h77, 0, 0, 0, 0, 0);
    tick();
    clr_wb();
    #1;
    check("pre_flush_count", {59'd0, count_out}, 64'd5);
    flush = 1'b1;
    commit_allow = 1'b1;
    alloc_req = 1'b1;
    set_wb(1, 4'd3, 32'h99, 0, 0, 0, 0, 0);
    #1;
    check("flush_fire", {62'd0, commit_fire}, 64'd0);
    check("flush_gnt", {63'd0, alloc_gnt}, 64'd0);
    tick();
    flush = 1'b0;
    alloc_req = 1'b0;
    clr_wb();
    tb_tail = 0;
    #1;
    check("flush_count", {59'd0, count_out}, 64'd0);
    check("flush_ptrs", {56'd0, head_ptr, tail_ptr}, 64'd0);
    check("flush_dump", {32'd0, dump_state}, 64'd0);

    // Reset mid-operation overrides a same-cycle allocation.
    commit_allow = 1'b0;
    for (int i = 0; i < 3; i++) alloc(5'(i), 1'b0, 0, 1'b0, 0);
    rst = 1'b1;
    alloc_req = 1'b1;
    tick();
    rst = 1'b0;
    alloc_req = 1'b0;
    #1;
    check("midrst_empty", {63'd0, empty}, 64'd1);
    check("midrst_tail", {60'd0, tail_ptr}, 64'd0);
    check("midrst_dump", {32'd0, dump_state}, 64'd0);

    check("sb_final", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
